// File: rtl/cpu_mem_arbiter_pkg.sv
// Shared types and sizes for the CPU memory arbiter slice.
package cpu_mem_arbiter_pkg;

  localparam int ADDR_SIZE = 32;
  localparam int DATA_SIZE = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arbState_e;

  // Width needed to hold a core index; never narrower than one bit.
  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cpu_mem_arbiter_rr_pick.sv
// Round-robin selector: first pending core strictly after the pointer, wrapping.
module cpu_mem_arbiter_rr_pick
  import cpu_mem_arbiter_pkg::*;
#(
  parameter int NCPU  = 4,
  parameter int IDX_W = idxWidth(NCPU)
) (
  input  logic [NCPU-1:0]  pend_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [NCPU-1:0]  grant_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  logic [IDX_W-1:0] cand;

  // Walk the cores in priority order starting just past the pointer, keep the first hit.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int k = 1; k <= NCPU; k++) begin
      cand = IDX_W'((int'(ptr_i) + k) % NCPU);
      if (!valid_o && pend_i[cand]) begin
        valid_o       = 1'b1;
        grant_o[cand] = 1'b1;
        idx_o         = cand;
      end
    end
  end

endmodule

// File: rtl/cpu_mem_arbiter.sv
// Round-robin arbiter between NCPU cores and one req/ack memory port, with a
// write-protect floor and an ack timeout. All outputs come straight from flops.
module cpu_mem_arbiter
  import cpu_mem_arbiter_pkg::*;
#(
  parameter int NCPU   = 4,
  parameter int ADDR_W = ADDR_SIZE,
  parameter int DATA_W = DATA_SIZE,
  parameter int TMO_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NCPU-1:0]          read_q,
  input  logic [NCPU-1:0]          write_q,
  input  logic [NCPU*ADDR_W-1:0]   addr_in,
  input  logic [NCPU*DATA_W-1:0]   data_in,
  output logic [DATA_W-1:0]        data_out,
  output logic [NCPU-1:0]          read_dn,
  output logic [NCPU-1:0]          write_dn,
  output logic                     bus_busy,
  input  logic [ADDR_W-1:0]        prot_limit,
  output logic                     prot_err,
  output logic                     tmo_err,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata,
  input  logic                     mem_ack
);

  localparam int IDX_W = idxWidth(NCPU);

  arbState_e        state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [NCPU-1:0]  mask_q, mask_d;
  logic [NCPU-1:0]  gntOh_q, gntOh_d;
  logic             refused_q, refused_d;
  logic [TMO_W-1:0] tmoCnt_q, tmoCnt_d;
  logic             memReq_q, memReq_d;
  logic             memWe_q, memWe_d;
  logic [ADDR_W-1:0] memAddr_q, memAddr_d;
  logic [DATA_W-1:0] memWdata_q, memWdata_d;
  logic [DATA_W-1:0] dataOut_q, dataOut_d;
  logic [NCPU-1:0]  readDn_q, readDn_d;
  logic [NCPU-1:0]  writeDn_q, writeDn_d;
  logic             busBusy_q, busBusy_d;
  logic             protErr_q, protErr_d;
  logic             tmoErr_q, tmoErr_d;

  logic [NCPU-1:0]   pending;
  logic [NCPU-1:0]   pickOh;
  logic [IDX_W-1:0]  pickIdx;
  logic              pickValid;
  logic [ADDR_W-1:0] selAddr;
  logic [DATA_W-1:0] selData;
  logic              selWrite;

  assign pending  = (read_q | write_q) & ~mask_q;
  assign selAddr  = addr_in[int'(pickIdx)*ADDR_W +: ADDR_W];
  assign selData  = data_in[int'(pickIdx)*DATA_W +: DATA_W];
  assign selWrite = write_q[pickIdx];

  cpu_mem_arbiter_rr_pick #(
    .NCPU  (NCPU),
    .IDX_W (IDX_W)
  ) uPick (
    .pend_i  (pending),
    .ptr_i   (ptr_q),
    .grant_o (pickOh),
    .idx_o   (pickIdx),
    .valid_o (pickValid)
  );

  // Next-state and next-output logic; pulses default low, everything else holds.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    mask_d     = mask_q;
    gntOh_d    = gntOh_q;
    refused_d  = refused_q;
    tmoCnt_d   = tmoCnt_q;
    memReq_d   = memReq_q;
    memWe_d    = memWe_q;
    memAddr_d  = memAddr_q;
    memWdata_d = memWdata_q;
    dataOut_d  = dataOut_q;
    busBusy_d  = busBusy_q;
    readDn_d   = '0;
    writeDn_d  = '0;
    protErr_d  = 1'b0;
    tmoErr_d   = 1'b0;
    case (state_q)
      IDLE: begin
        mask_d = '0;
        if (pickValid) begin
          ptr_d      = pickIdx;
          gntOh_d    = pickOh;
          memWe_d    = selWrite;
          memAddr_d  = selAddr;
          memWdata_d = selData;
          refused_d  = selWrite && (selAddr < prot_limit);
          memReq_d   = !(selWrite && (selAddr < prot_limit));
          tmoCnt_d   = '0;
          busBusy_d  = 1'b1;
          state_d    = ISSUE;
        end
      end
      ISSUE, WAIT: begin
        if (refused_q) begin
          writeDn_d = gntOh_q;
          protErr_d = 1'b1;
          state_d   = DONE;
        end else if (mem_ack) begin
          memReq_d = 1'b0;
          if (memWe_q) begin
            writeDn_d = gntOh_q;
          end else begin
            readDn_d  = gntOh_q;
            dataOut_d = mem_rdata;
          end
          state_d = DONE;
        end else if (&tmoCnt_q) begin
          memReq_d = 1'b0;
          tmoErr_d = 1'b1;
          if (memWe_q) begin
            writeDn_d = gntOh_q;
          end else begin
            readDn_d  = gntOh_q;
            dataOut_d = '1;
          end
          state_d = DONE;
        end else begin
          tmoCnt_d = tmoCnt_q + 1'b1;
          state_d  = WAIT;
        end
      end
      DONE: begin
        busBusy_d = 1'b0;
        mask_d    = gntOh_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any access and points rr at the last core.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= IDX_W'(NCPU - 1);
      mask_q     <= '0;
      gntOh_q    <= '0;
      refused_q  <= 1'b0;
      tmoCnt_q   <= '0;
      memReq_q   <= 1'b0;
      memWe_q    <= 1'b0;
      memAddr_q  <= '0;
      memWdata_q <= '0;
      dataOut_q  <= '0;
      readDn_q   <= '0;
      writeDn_q  <= '0;
      busBusy_q  <= 1'b0;
      protErr_q  <= 1'b0;
      tmoErr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      mask_q     <= mask_d;
      gntOh_q    <= gntOh_d;
      refused_q  <= refused_d;
      tmoCnt_q   <= tmoCnt_d;
      memReq_q   <= memReq_d;
      memWe_q    <= memWe_d;
      memAddr_q  <= memAddr_d;
      memWdata_q <= memWdata_d;
      dataOut_q  <= dataOut_d;
      readDn_q   <= readDn_d;
      writeDn_q  <= writeDn_d;
      busBusy_q  <= busBusy_d;
      protErr_q  <= protErr_d;
      tmoErr_q   <= tmoErr_d;
    end
  end

  assign data_out  = dataOut_q;
  assign read_dn   = readDn_q;
  assign write_dn  = writeDn_q;
  assign bus_busy  = busBusy_q;
  assign prot_err  = protErr_q;
  assign tmo_err   = tmoErr_q;
  assign mem_req   = memReq_q;
  assign mem_we    = memWe_q;
  assign mem_addr  = memAddr_q;
  assign mem_wdata = memWdata_q;

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Self-checking bench: transaction-level model compared every cycle, plus
// hand-computed latency/ordering expectations in the directed tests.
module tb_cpu_mem_arbiter;

  localparam int NCPU  = 4;
  localparam int TMO_W = 8;
  localparam int TMO_LIMIT = (1 << TMO_W) - 1;

  logic              clk;
  logic              rst;
  logic [NCPU-1:0]   read_q;
  logic [NCPU-1:0]   write_q;
  logic [NCPU*32-1:0] addr_in;
  logic [NCPU*32-1:0] data_in;
  logic [31:0]       data_out;
  logic [NCPU-1:0]   read_dn;
  logic [NCPU-1:0]   write_dn;
  logic              bus_busy;
  logic [31:0]       prot_limit;
  logic              prot_err;
  logic              tmo_err;
  logic              mem_req;
  logic              mem_we;
  logic [31:0]       mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata = '0;
  logic              mem_ack = 1'b0;

  int total = 0;
  int bad   = 0;

  bit          memEn;
  int          memDelay;
  logic [31:0] memData;
  int          memSeen = 0;

  cpu_mem_arbiter #(
    .NCPU   (NCPU),
    .ADDR_W (32),
    .DATA_W (32),
    .TMO_W  (TMO_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .read_q     (read_q),
    .write_q    (write_q),
    .addr_in    (addr_in),
    .data_in    (data_in),
    .data_out   (data_out),
    .read_dn    (read_dn),
    .write_dn   (write_dn),
    .bus_busy   (bus_busy),
    .prot_limit (prot_limit),
    .prot_err   (prot_err),
    .tmo_err    (tmo_err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something never returns.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int core, input bit rd, input bit wr,
                               input logic [31:0] addr, input logic [31:0] data);
    read_q[core]          = rd;
    write_q[core]         = wr;
    addr_in[core*32 +: 32] = addr;
    data_in[core*32 +: 32] = data;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic waitDn(input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!((|read_dn) || (|write_dn)) && n < budget);
    if (!((|read_dn) || (|write_dn)))
      checkOutput("dn_wait_expired", 64'(n), 64'(budget + 1));
  endtask

  // Memory responder: acks memDelay cycles after the request is first seen.
  always @(negedge clk) begin
    #1;
    if (mem_req === 1'b1) begin
      if (memEn && memSeen == memDelay) begin
        mem_ack   = 1'b1;
        mem_rdata = memData;
      end else begin
        mem_ack = 1'b0;
      end
      memSeen++;
    end else begin
      mem_ack = 1'b0;
      memSeen = 0;
    end
  end

  // Transaction-level reference model: a transaction is granted, runs for a
  // number of cycles decided by ack/refusal/timeout, then finishes.
  int          mPhase;
  int          mCore, mRr, mBlocked, mAge, mPick, mCand;
  bit          mWrite, mRefused;
  logic [31:0] mAddr, mData;
  logic        eReq, eWe, eBusy, eProt, eTmo;
  logic [31:0] eAddr, eWdata, eDout;
  logic [NCPU-1:0] eRd, eWr;

  task automatic modelFinish();
    if (mWrite) eWr[mCore] = 1'b1;
    else        eRd[mCore] = 1'b1;
    mPhase = 2;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mPhase = 0; mRr = NCPU - 1; mBlocked = -1; mCore = 0; mAge = 0;
      mWrite = 0; mRefused = 0; mAddr = '0; mData = '0;
      eReq = 0; eWe = 0; eBusy = 0; eProt = 0; eTmo = 0;
      eAddr = '0; eWdata = '0; eDout = '0; eRd = '0; eWr = '0;
    end else begin
      eRd = '0; eWr = '0; eProt = 0; eTmo = 0;
      if (mPhase == 2) begin
        eBusy    = 0;
        mBlocked = mCore;
        mPhase   = 0;
      end else if (mPhase == 1) begin
        if (mRefused) begin
          eProt = 1;
          modelFinish();
        end else if (mem_ack) begin
          eReq = 0;
          if (!mWrite) eDout = mem_rdata;
          modelFinish();
        end else if (mAge == TMO_LIMIT) begin
          eReq = 0;
          eTmo = 1;
          if (!mWrite) eDout = 32'hFFFF_FFFF;
          modelFinish();
        end else begin
          mAge++;
        end
      end else begin
        mPick = -1;
        for (int k = 1; k <= NCPU; k++) begin
          mCand = (mRr + k) % NCPU;
          if (mPick < 0 && mCand != mBlocked && (read_q[mCand] || write_q[mCand]))
            mPick = mCand;
        end
        mBlocked = -1;
        if (mPick >= 0) begin
          mCore    = mPick;
          mRr      = mPick;
          mWrite   = write_q[mPick];
          mAddr    = addr_in[mPick*32 +: 32];
          mData    = data_in[mPick*32 +: 32];
          mRefused = mWrite && (mAddr < prot_limit);
          mAge     = 0;
          eBusy    = 1;
          if (!mRefused) begin
            eReq   = 1;
            eWe    = mWrite;
            eAddr  = mAddr;
            eWdata = mData;
          end
          mPhase = 1;
        end
      end
    end
  end

  // Cycle-by-cycle comparison of the DUT against the model, mid-cycle.
  always @(negedge clk) begin
    checkOutput("mem_req",  64'(mem_req),  64'(eReq));
    checkOutput("bus_busy", 64'(bus_busy), 64'(eBusy));
    checkOutput("read_dn",  64'(read_dn),  64'(eRd));
    checkOutput("write_dn", 64'(write_dn), 64'(eWr));
    checkOutput("prot_err", 64'(prot_err), 64'(eProt));
    checkOutput("tmo_err",  64'(tmo_err),  64'(eTmo));
    checkOutput("data_out", 64'(data_out), 64'(eDout));
    if (eReq) begin
      checkOutput("mem_we",    64'(mem_we),    64'(eWe));
      checkOutput("mem_addr",  64'(mem_addr),  64'(eAddr));
      checkOutput("mem_wdata", 64'(mem_wdata), 64'(eWdata));
    end
  end

  logic [NCPU-1:0] rrOrder [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
  int              rrGap   [4] = '{2, 3, 3, 3};

  initial begin
    int n;
    read_q     = '0;
    write_q    = '0;
    addr_in    = '0;
    data_in    = '0;
    prot_limit = '0;
    memEn      = 1'b1;
    memDelay   = 0;
    memData    = '0;
    rst        = 1'b0;
    #1 rst = 1'b1;

    // Reset state
    @(negedge clk);
    checkOutput("rst_mem_req",  64'(mem_req),  64'd0);
    checkOutput("rst_bus_busy", 64'(bus_busy), 64'd0);
    checkOutput("rst_dn",       64'({read_dn, write_dn}), 64'd0);
    checkOutput("rst_data_out", 64'(data_out), 64'd0);
    #1 rst = 1'b0;
    idleCycles(1);

    // All four cores write at once: served 0,1,2,3, three cycles apart.
    for (int i = 0; i < NCPU; i++)
      applyStimulus(i, 1'b0, 1'b1, 32'h2000 + 32'(i * 4), 32'hA0 + 32'(i));
    for (int i = 0; i < NCPU; i++) begin
      waitDn(20, n);
      checkOutput("rr_gap",   64'(n),        64'(rrGap[i]));
      checkOutput("rr_order", 64'(write_dn), 64'(rrOrder[i]));
      #1 applyStimulus(i, 1'b0, 1'b0, 32'h2000 + 32'(i * 4), 32'hA0 + 32'(i));
    end

    // Single read, memory acks one cycle after the request.
    idleCycles(2);
    memDelay = 1;
    memData  = 32'hDEAD_BEEF;
    applyStimulus(0, 1'b1, 1'b0, 32'h100, 32'h0);
    waitDn(20, n);
    checkOutput("rd_latency",  64'(n),        64'd3);
    checkOutput("rd_dn",       64'(read_dn),  64'h1);
    checkOutput("rd_data",     64'(data_out), 64'hDEAD_BEEF);
    checkOutput("rd_busy",     64'(bus_busy), 64'd1);
    #1 applyStimulus(0, 1'b0, 1'b0, 32'h100, 32'h0);

    // Write below the protect floor is refused, write at the floor goes through.
    idleCycles(2);
    memDelay   = 0;
    prot_limit = 32'h1000;
    applyStimulus(2, 1'b0, 1'b1, 32'h0FFC, 32'h55);
    waitDn(20, n);
    checkOutput("prot_latency", 64'(n),        64'd2);
    checkOutput("prot_dn",      64'(write_dn), 64'h4);
    checkOutput("prot_flag",    64'(prot_err), 64'd1);
    #1 applyStimulus(2, 1'b0, 1'b0, 32'h0FFC, 32'h55);
    idleCycles(2);
    applyStimulus(2, 1'b0, 1'b1, 32'h1000, 32'h66);
    waitDn(20, n);
    checkOutput("floor_latency", 64'(n),        64'd2);
    checkOutput("floor_dn",      64'(write_dn), 64'h4);
    checkOutput("floor_flag",    64'(prot_err), 64'd0);
    #1 applyStimulus(2, 1'b0, 1'b0, 32'h1000, 32'h66);

    // Ack withheld: timeout completes the read with all ones.
    idleCycles(2);
    memEn = 1'b0;
    applyStimulus(3, 1'b1, 1'b0, 32'h300, 32'h0);
    waitDn(400, n);
    checkOutput("tmo_latency", 64'(n),        64'd257);
    checkOutput("tmo_dn",      64'(read_dn),  64'h8);
    checkOutput("tmo_flag",    64'(tmo_err),  64'd1);
    checkOutput("tmo_data",    64'(data_out), 64'hFFFF_FFFF);
    #1 applyStimulus(3, 1'b0, 1'b0, 32'h300, 32'h0);

    // Next request is normal; it is dropped mid-transaction but still completes.
    idleCycles(2);
    memEn    = 1'b1;
    memData  = 32'h1234_5678;
    applyStimulus(1, 1'b1, 1'b0, 32'h104, 32'h0);
    idleCycles(1);
    applyStimulus(1, 1'b0, 1'b0, 32'h104, 32'h0);
    waitDn(20, n);
    checkOutput("after_tmo_latency", 64'(n),        64'd1);
    checkOutput("after_tmo_dn",      64'(read_dn),  64'h2);
    checkOutput("after_tmo_data",    64'(data_out), 64'h1234_5678);

    // Core 1 asks for both: write first, write_q held into the masked cycle, then read.
    idleCycles(2);
    memData = 32'hCAFE_F00D;
    applyStimulus(1, 1'b1, 1'b1, 32'h2100, 32'h77);
    waitDn(20, n);
    checkOutput("both_wr_latency", 64'(n),        64'd2);
    checkOutput("both_wr_dn",      64'(write_dn), 64'h2);
    checkOutput("both_wr_nord",    64'(read_dn),  64'h0);
    idleCycles(2);
    applyStimulus(1, 1'b1, 1'b0, 32'h2100, 32'h77);
    waitDn(20, n);
    checkOutput("both_rd_latency", 64'(n),        64'd2);
    checkOutput("both_rd_dn",      64'(read_dn),  64'h2);
    checkOutput("both_rd_data",    64'(data_out), 64'hCAFE_F00D);
    #1 applyStimulus(1, 1'b0, 1'b0, 32'h2100, 32'h77);

    // Reset during WAIT aborts at once; afterwards core 0 beats core 3.
    idleCycles(2);
    memEn = 1'b0;
    applyStimulus(2, 1'b1, 1'b0, 32'h208, 32'h0);
    idleCycles(5);
    rst = 1'b1;
    applyStimulus(2, 1'b0, 1'b0, 32'h208, 32'h0);
    #1;
    checkOutput("abort_mem_req",  64'(mem_req),  64'd0);
    checkOutput("abort_bus_busy", 64'(bus_busy), 64'd0);
    idleCycles(1);
    rst      = 1'b0;
    memEn    = 1'b1;
    memData  = 32'hBEEF_0000;
    applyStimulus(0, 1'b1, 1'b0, 32'h400, 32'h0);
    applyStimulus(3, 1'b1, 1'b0, 32'h500, 32'h0);
    waitDn(20, n);
    checkOutput("post_rst_latency", 64'(n),        64'd2);
    checkOutput("post_rst_first",   64'(read_dn),  64'h1);
    checkOutput("post_rst_data",    64'(data_out), 64'hBEEF_0000);
    #1 applyStimulus(0, 1'b0, 1'b0, 32'h400, 32'h0);
    waitDn(20, n);
    checkOutput("post_rst_gap",    64'(n),       64'd3);
    checkOutput("post_rst_second", 64'(read_dn), 64'h8);
    #1 applyStimulus(3, 1'b0, 1'b0, 32'h500, 32'h0);
    idleCycles(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
